// File: rtl/gcd_engine.sv
// gcd_engine: start/ready request side, done/ack result side; GCD by repeated
// subtraction (mode=0) or Stein's binary algorithm (mode=1).
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, ready      request handshake; a_in, b_in, mode captured on accept
//   ack, done         result handshake; gcd_out, cycles, zero_err valid with done
//   busy              computation in progress
//   cycles            RUN cycles spent on the request, saturating
//   zero_err          both operands were zero
module gcd_engine #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ITER_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ready,
    input  logic              mode,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    input  logic              ack,
    output logic              done,
    output logic              busy,
    output logic [WIDTH-1:0]  gcd_out,
    output logic [ITER_W-1:0] cycles,
    output logic              zero_err
);

    localparam int unsigned K_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic                md_q, md_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [WIDTH-1:0]    gcd_q, gcd_d;
    logic [ITER_W-1:0]   cycles_q, cycles_d;
    logic                zero_err_q, zero_err_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ITER_W-1:0]   cycles_inc;

    // Next-state and datapath update; handshake flags follow the next state
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        md_d       = md_q;
        k_d        = k_q;
        gcd_d      = gcd_q;
        cycles_d   = cycles_q;
        zero_err_d = zero_err_q;
        cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + ITER_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d        = a_in;
                    b_d        = b_in;
                    md_d       = mode;
                    cycles_d   = '0;
                    k_d        = '0;
                    zero_err_d = 1'b0;
                    // A zero operand short-circuits: gcd(x,0) = x
                    if ((a_in == '0) || (b_in == '0)) begin
                        gcd_d      = a_in | b_in;
                        zero_err_d = (a_in == '0) && (b_in == '0);
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                cycles_d = cycles_inc;
                if (a_q == b_q) begin
                    // Binary mode restores the common power of two stripped earlier
                    gcd_d   = md_q ? (a_q << k_q) : a_q;
                    state_d = S_DONE;
                end else if (!md_q) begin
                    if (a_q > b_q) begin
                        a_d = a_q - b_q;
                    end else begin
                        b_d = b_q - a_q;
                    end
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + K_W'(1);
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    // Difference of two odd values is even, so halve it at once
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            md_q       <= 1'b0;
            k_q        <= '0;
            gcd_q      <= '0;
            cycles_q   <= '0;
            zero_err_q <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            md_q       <= md_d;
            k_q        <= k_d;
            gcd_q      <= gcd_d;
            cycles_q   <= cycles_d;
            zero_err_q <= zero_err_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign gcd_out  = gcd_q;
    assign cycles   = cycles_q;
    assign zero_err = zero_err_q;

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed requests against a behavioural GCD/iteration model,
// with a per-cycle compare process and literal expectations for each vector.
module tb_gcd_engine;

    localparam int unsigned W     = 16;
    localparam int unsigned IW    = 16;
    localparam int          BOUND = 70000;

    logic          clk;
    logic          rst;
    logic          start;
    logic          ready;
    logic          mode;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          ack;
    logic          done;
    logic          busy;
    logic [W-1:0]  gcd_out;
    logic [IW-1:0] cycles;
    logic          zero_err;

    int            checks;
    int            errors;
    logic          chk_en;
    logic          exp_valid;
    logic [W-1:0]  exp_gcd;
    logic [IW-1:0] exp_cyc;
    logic          exp_zerr;

    gcd_engine #(.WIDTH(W), .ITER_W(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ready    (ready),
        .mode     (mode),
        .a_in     (a_in),
        .b_in     (b_in),
        .ack      (ack),
        .done     (done),
        .busy     (busy),
        .gcd_out  (gcd_out),
        .cycles   (cycles),
        .zero_err (zero_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: gcd by Euclid's modulo; cycle count from the request rules
    // (subtractive mode counted in whole quotients, binary mode step by step).
    function automatic void model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] g, output longint steps, output logic z);
        longint x, y, q, t;
        z = (a == 0) && (b == 0);
        if ((a == 0) || (b == 0)) begin
            g     = a | b;
            steps = 0;
            return;
        end
        x = longint'(a);
        y = longint'(b);
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        g = W'(x);
        x = longint'(a);
        y = longint'(b);
        steps = 1;
        if (!m) begin
            while (x != y) begin
                if (x > y) begin
                    q = (x - 1) / y;
                    x = x - q * y;
                end else begin
                    q = (y - 1) / x;
                    y = y - q * x;
                end
                steps += q;
            end
        end else begin
            while (x != y) begin
                steps++;
                if ((x % 2 == 0) && (y % 2 == 0)) begin
                    x = x / 2;
                    y = y / 2;
                end else if (x % 2 == 0) begin
                    x = x / 2;
                end else if (y % 2 == 0) begin
                    y = y / 2;
                end else if (x > y) begin
                    x = (x - y) / 2;
                end else begin
                    y = (y - x) / 2;
                end
            end
        end
    endfunction

    // Compare process: handshake flags one-hot every cycle; result fields
    // match the model for as long as done is held.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("onehot_state", 64'(int'(ready) + int'(busy) + int'(done)), 64'd1);
            if (done && exp_valid) begin
                chk("mon_gcd", 64'(gcd_out), 64'(exp_gcd));
                chk("mon_cycles", 64'(cycles), 64'(exp_cyc));
                chk("mon_zero_err", 64'(zero_err), 64'(exp_zerr));
            end
        end
    end

    task automatic do_req(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] lit_g, input longint lit_c, input logic lit_z,
                          input int hold);
        logic [W-1:0] g;
        longint       steps;
        logic         z;
        int           lat;
        longint       exp_lat;
        model(m, a, b, g, steps, z);
        chk("model_gcd", 64'(g), 64'(lit_g));
        chk("model_cycles", 64'(steps > 65535 ? 65535 : steps), 64'(lit_c));
        chk("model_zero_err", 64'(z), 64'(lit_z));
        exp_gcd   = g;
        exp_cyc   = IW'(steps > 65535 ? 65535 : steps);
        exp_zerr  = z;
        exp_lat   = (steps == 0) ? 1 : steps + 1;
        exp_valid = 1'b1;
        chk("ready_before_req", 64'(ready), 64'd1);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = ~m;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        lat = 1;
        while (!done && lat < BOUND) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("dut_gcd", 64'(gcd_out), 64'(lit_g));
        chk("dut_cycles", 64'(cycles), 64'(lit_c));
        chk("dut_zero_err", 64'(zero_err), 64'(lit_z));
        // Hold the result; start pulses while done must be ignored
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            start = 1'(i % 2);
            mode  = 1'($urandom);
            a_in  = W'($urandom);
            b_in  = W'($urandom);
        end
        @(negedge clk);
        start = (hold > 0);
        ack   = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        ack       = 1'b0;
        exp_valid = 1'b0;
        chk("done_after_ack", 64'(done), 64'd0);
        chk("ready_after_ack", 64'(ready), 64'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        chk_en    = 1'b0;
        exp_valid = 1'b0;
        exp_gcd   = '0;
        exp_cyc   = '0;
        exp_zerr  = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        a_in      = '0;
        b_in      = '0;
        ack       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gcd", 64'(gcd_out), 64'd0);
        chk("rst_cycles", 64'(cycles), 64'd0);
        chk("rst_zero_err", 64'(zero_err), 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        do_req(1'b0, 16'd48,    16'd18,    16'd6,     5,     1'b0, 0);
        do_req(1'b1, 16'd48,    16'd18,    16'd6,     6,     1'b0, 10);
        do_req(1'b1, 16'd12,    16'd8,     16'd4,     5,     1'b0, 0);
        do_req(1'b0, 16'd0,     16'd25,    16'd25,    0,     1'b0, 1);
        do_req(1'b1, 16'd0,     16'd25,    16'd25,    0,     1'b0, 0);
        do_req(1'b0, 16'd25,    16'd0,     16'd25,    0,     1'b0, 0);
        do_req(1'b1, 16'd0,     16'd0,     16'd0,     0,     1'b1, 2);
        do_req(1'b1, 16'd7,     16'd7,     16'd7,     1,     1'b0, 0);
        do_req(1'b0, 16'd100,   16'd75,    16'd25,    4,     1'b0, 0);
        do_req(1'b1, 16'd100,   16'd75,    16'd25,    4,     1'b0, 0);
        do_req(1'b1, 16'd32768, 16'd16384, 16'd16384, 16,    1'b0, 0);
        do_req(1'b1, 16'd65535, 16'd1,     16'd1,     16,    1'b0, 0);
        do_req(1'b0, 16'd65535, 16'd1,     16'd1,     65535, 1'b0, 3);

        // Reset in the middle of a long computation discards it
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        a_in  = 16'd1000;
        b_in  = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        chk("ack_ignored_in_run", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", 64'(ready), 64'd1);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_cycles", 64'(cycles), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 16'd21, 16'd14, 16'd7, 3, 1'b0, 2);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
